// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arbiter_pkg;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between fetch (read-only) and the data stage (read/write).
// Data side wins, but fetch is forced in after STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_read,
    input  rv32i_word      i_addr,
    output rv32i_word      i_rdata,
    output logic           i_resp,
    input  logic           d_read,
    input  logic           d_write,
    input  rv32i_mem_wmask d_wmask,
    input  rv32i_word      d_addr,
    input  rv32i_word      d_wdata,
    output rv32i_word      d_rdata,
    output logic           d_resp,
    output logic           mem_read,
    output logic           mem_write,
    output rv32i_mem_wmask mem_byte_enable,
    output rv32i_word      mem_address,
    output rv32i_word      mem_wdata,
    input  logic           mem_resp,
    input  rv32i_word      mem_rdata,
    output logic           busy
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    arb_state_t     state_q, state_d;
    logic [3:0]     starve_cnt_q, starve_cnt_d;
    logic           is_write_q, is_write_d;
    rv32i_word      addr_q, addr_d;
    rv32i_word      wdata_q, wdata_d;
    rv32i_mem_wmask wmask_q, wmask_d;
    rv32i_word      i_rdata_q, d_rdata_q;
    logic           d_pending, d_wins;

    assign d_pending = d_read | d_write;
    assign d_wins    = d_pending && ((starve_cnt_q < Limit) || !i_read);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        is_write_d   = is_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d = SERVE_D;
                    // Only count data grants that actually made a fetch wait.
                    if (i_read) begin
                        starve_cnt_d = (starve_cnt_q < Limit) ? starve_cnt_q + 4'd1 : Limit;
                    end else begin
                        starve_cnt_d = '0;
                    end
                    is_write_d = d_write;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    wmask_d    = d_wmask;
                end else if (i_read) begin
                    state_d      = SERVE_I;
                    starve_cnt_d = '0;
                    is_write_d   = 1'b0;
                    addr_d       = i_addr;
                    wdata_d      = '0;
                    wmask_d      = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            if (i_resp) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_resp) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // Responses are suppressed during reset so an aborted access never completes.
    assign i_resp = !rst && (state_q == SERVE_I) && mem_resp;
    assign d_resp = !rst && (state_q == SERVE_D) && mem_resp;
    assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
    assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

    assign mem_read        = (state_q == SERVE_I) || ((state_q == SERVE_D) && !is_write_q);
    assign mem_write       = (state_q == SERVE_D) && is_write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = wmask_q;
    assign busy            = (state_q != IDLE);

    d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requesters and a memory responder with random latency,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int unsigned Limit   = 4;
    localparam int          OwnNone = 0;
    localparam int          OwnI    = 1;
    localparam int          OwnD    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_arbiter #(
        .STARVE_LIMIT(Limit)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .i_resp          (i_resp),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_wmask         (d_wmask),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_resp          (d_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who owns the port, how many data grants in a row kept fetch waiting,
    // what was captured at grant, and the last data each side received.
    int          owner;
    int          d_streak;
    int          wait_cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] hold_i;
    logic [31:0] hold_d;
    logic        exp_i_resp;
    logic        exp_d_resp;
    bit          phase_full;

    initial begin
        rst       = 1'b1;
        i_read    = 1'b0;
        i_addr    = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_wmask   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        owner     = OwnNone;
        d_streak  = 0;
        wait_cnt  = 0;
        lat_write = 1'b0;
        lat_addr  = '0;
        lat_wdata = '0;
        lat_be    = '0;
        hold_i    = '0;
        hold_d    = '0;
        phase_full = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_mem_address", mem_address, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_mem_be", mem_byte_enable, 4'h0);
        check_eq("rst_i_resp", i_resp, 1'b0);
        check_eq("rst_d_resp", d_resp, 1'b0);
        check_eq("rst_i_rdata", i_rdata, 32'h0);
        check_eq("rst_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            // Advance the model by the edge that just happened, using the inputs it saw.
            if (rst) begin
                owner    = OwnNone;
                d_streak = 0;
                lat_write = 1'b0;
                lat_addr  = '0;
                lat_wdata = '0;
                lat_be    = '0;
                hold_i    = '0;
                hold_d    = '0;
            end else if (owner == OwnNone) begin
                if ((d_read || d_write) && (d_streak < int'(Limit) || !i_read)) begin
                    owner     = OwnD;
                    d_streak  = i_read ? d_streak + 1 : 0;
                    lat_write = d_write;
                    lat_addr  = d_addr;
                    lat_wdata = d_wdata;
                    lat_be    = d_wmask;
                    wait_cnt  = $urandom_range(0, 3);
                end else if (i_read) begin
                    owner     = OwnI;
                    d_streak  = 0;
                    lat_write = 1'b0;
                    lat_addr  = i_addr;
                    wait_cnt  = $urandom_range(0, 3);
                end
            end else if (mem_resp) begin
                if (owner == OwnI) begin
                    hold_i = mem_rdata;
                    i_read = 1'b0;
                end else begin
                    hold_d  = mem_rdata;
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
                owner = OwnNone;
            end

            check_eq("busy", busy, owner != OwnNone);
            check_eq("mem_read", mem_read, (owner == OwnI) || (owner == OwnD && !lat_write));
            check_eq("mem_write", mem_write, (owner == OwnD) && lat_write);
            if (owner != OwnNone) begin
                check_eq("mem_address", mem_address, lat_addr);
            end
            if (owner == OwnD) begin
                check_eq("mem_wdata", mem_wdata, lat_wdata);
                check_eq("mem_be", mem_byte_enable, lat_be);
            end

            // Next cycle's stimulus.
            phase_full = (cyc >= 2000);
            rst = (cyc > 100) && ($urandom_range(0, 149) == 0);

            if (!i_read) begin
                if (phase_full || $urandom_range(0, 2) == 0) begin
                    i_read = 1'b1;
                    i_addr = $urandom & 32'hFFFF_FFFC;
                end
            end else if (owner == OwnI && $urandom_range(0, 3) == 0) begin
                i_addr = $urandom;
            end

            if (!(d_read || d_write)) begin
                if (phase_full || $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 1) d_write = 1'b1;
                    else d_read = 1'b1;
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_wmask = 4'($urandom);
                end
            end else if (owner == OwnD && $urandom_range(0, 3) == 0) begin
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wmask = 4'($urandom);
            end

            mem_rdata = $urandom;
            if (owner != OwnNone) begin
                if (wait_cnt == 0) begin
                    mem_resp = 1'b1;
                end else begin
                    wait_cnt--;
                    mem_resp = 1'b0;
                end
            end else begin
                mem_resp = ($urandom_range(0, 7) == 0);
            end

            @(negedge clk);
            exp_i_resp = !rst && (owner == OwnI) && mem_resp;
            exp_d_resp = !rst && (owner == OwnD) && mem_resp;
            check_eq("i_resp", i_resp, exp_i_resp);
            check_eq("d_resp", d_resp, exp_d_resp);
            check_eq("i_rdata", i_rdata, exp_i_resp ? mem_rdata : hold_i);
            check_eq("d_rdata", d_rdata, exp_d_resp ? mem_rdata : hold_d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
